// File: rtl/display_pkg.sv
// Shared constants, conversion FSM states and the power-of-ten helper used by
// the multi-digit 7-segment display driver.
package display_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [7:0] EN_ALL_OFF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_t;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential shift-add-3 binary to BCD converter: watches i_number, reconverts
// whenever it differs from the last captured value, flags overflow at the end.
module bin_to_bcd
    import display_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [WIDTH-1:0]      i_number,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic                  o_busy
);

    localparam int          BCD_W = 4 * DIGITS;
    localparam int          CNT_W = $clog2(WIDTH + 1);
    localparam logic [31:0] LIMIT = pow10(DIGITS);

    conv_state_t        r_state, w_state_next;
    logic               r_pending;
    logic [WIDTH-1:0]   r_last_value;
    logic [WIDTH-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [CNT_W-1:0]   r_shift_cnt;
    logic               r_overflow;
    logic               r_busy;
    logic               w_start;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending || (i_number != r_last_value)) begin
                    w_start      = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_shift_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                o_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= IDLE;
            r_pending    <= 1'b1;
            r_last_value <= '0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_shift_cnt  <= '0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_pending    <= 1'b0;
                r_last_value <= i_number;
                r_bin        <= i_number;
                r_bcd        <= '0;
                r_shift_cnt  <= '0;
                r_busy       <= 1'b1;
            end
            if (r_state == SHIFT) begin
                r_bcd       <= {w_bcd_adj[BCD_W-2:0], r_bin[WIDTH-1]};
                r_bin       <= r_bin << 1;
                r_shift_cnt <= r_shift_cnt + CNT_W'(1);
            end
            // Overflow is judged on the captured binary, so truncated BCD never matters
            if (o_done) begin
                r_overflow <= (32'(r_last_value) >= LIMIT);
                r_busy     <= 1'b0;
            end
        end
    end

    assign o_bcd      = r_bcd;
    assign o_overflow = r_overflow;
    assign o_busy     = r_busy;

endmodule

// File: rtl/seven_segment.sv
// Hex-to-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}; code F is blank.
module seven_segment (
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'b1111111;
        case (i_code)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/multi_digit_display.sv
// N-digit multiplexed decimal display: BCD conversion, overflow/leading-zero
// blanking and a free-running digit scan feeding one shared segment decoder.
module multi_digit_display
    import display_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int WIDTH     = 14,
    parameter int SCAN_BITS = 17,
    parameter int BLANK_LZ  = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Number,
    output logic [6:0]       out7,
    output logic [7:0]       en_out,
    output logic             Overflow,
    output logic             Busy
);

    logic [4*DIGITS-1:0]     w_bcd;
    logic                    w_done;
    logic [DIGITS-1:0][3:0]  r_digits;
    logic [DIGITS-1:0]       w_upper_nz;
    logic [7:0][3:0]         w_slot_code;
    logic [SCAN_BITS-1:0]    r_cnt;
    logic [2:0]              r_idx;
    logic [7:0]              r_en;
    logic [3:0]              r_code;

    bin_to_bcd #(
        .DIGITS (DIGITS),
        .WIDTH  (WIDTH)
    ) u_bin_to_bcd (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_number   (Number),
        .o_bcd      (w_bcd),
        .o_done     (w_done),
        .o_overflow (Overflow),
        .o_busy     (Busy)
    );

    // w_upper_nz[i] is set when any digit at position i or above is non-zero
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nz
            if (gi == DIGITS - 1) begin : g_top
                assign w_upper_nz[gi] = |r_digits[gi];
            end else begin : g_lower
                assign w_upper_nz[gi] = (|r_digits[gi]) | w_upper_nz[gi+1];
            end
        end

        for (gi = 0; gi < 8; gi++) begin : g_slot
            if (gi < DIGITS) begin : g_used
                assign w_slot_code[gi] =
                    Overflow ? BLANK_CODE :
                    ((BLANK_LZ != 0) && (gi > 0) && !w_upper_nz[gi]) ? BLANK_CODE :
                    r_digits[gi];
            end else begin : g_unused
                assign w_slot_code[gi] = BLANK_CODE;
            end
        end
    endgenerate

    // Enable and digit code register together so a slot never shows its neighbour's value
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt    <= '0;
            r_idx    <= 3'd0;
            r_en     <= EN_ALL_OFF;
            r_code   <= BLANK_CODE;
            r_digits <= '0;
        end else begin
            r_cnt <= r_cnt + SCAN_BITS'(1);
            if (&r_cnt) begin
                r_idx <= (r_idx == 3'(DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
            end
            r_en   <= ~(8'd1 << r_idx);
            r_code <= w_slot_code[r_idx];
            if (w_done) begin
                r_digits <= w_bcd;
            end
        end
    end

    assign en_out = r_en;

    seven_segment u_seven_segment (
        .i_code (r_code),
        .o_seg  (out7)
    );

endmodule

// File: tb/tb_multi_digit_display.sv
// Directed bench for multi_digit_display: 4-digit (with and without blanking),
// 8-digit and 3-digit instances, digits recovered from out7 per enabled slot.
module tb_multi_digit_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] number = 14'd0;
    logic [26:0] number8 = 27'd12345678;

    logic [6:0] out7_m, out7_z, out7_8, out7_3;
    logic [7:0] en_m, en_z, en_8, en_3;
    logic       ov_m, ov_z, ov_8, ov_3;
    logic       busy_m, busy_z, busy_8, busy_3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multi_digit_display #(.DIGITS(4), .WIDTH(14), .SCAN_BITS(2), .BLANK_LZ(1)) u_dut (
        .Clk(clk), .Rst(rst), .Number(number), .out7(out7_m), .en_out(en_m),
        .Overflow(ov_m), .Busy(busy_m));

    multi_digit_display #(.DIGITS(4), .WIDTH(14), .SCAN_BITS(2), .BLANK_LZ(0)) u_dut_nz (
        .Clk(clk), .Rst(rst), .Number(number), .out7(out7_z), .en_out(en_z),
        .Overflow(ov_z), .Busy(busy_z));

    multi_digit_display #(.DIGITS(8), .WIDTH(27), .SCAN_BITS(2), .BLANK_LZ(1)) u_dut8 (
        .Clk(clk), .Rst(rst), .Number(number8), .out7(out7_8), .en_out(en_8),
        .Overflow(ov_8), .Busy(busy_8));

    multi_digit_display #(.DIGITS(3), .WIDTH(14), .SCAN_BITS(2), .BLANK_LZ(1)) u_dut3 (
        .Clk(clk), .Rst(rst), .Number(number), .out7(out7_3), .en_out(en_3),
        .Overflow(ov_3), .Busy(busy_3));

    // Segment pattern -> digit code; 5'h0F = blank, 5'h1F = unrecognised pattern
    function automatic logic [4:0] seg2code(input logic [6:0] s);
        logic [4:0] c;
        case (s)
            7'b1000000: c = 5'd0;
            7'b1111001: c = 5'd1;
            7'b0100100: c = 5'd2;
            7'b0110000: c = 5'd3;
            7'b0011001: c = 5'd4;
            7'b0010010: c = 5'd5;
            7'b0000010: c = 5'd6;
            7'b1111000: c = 5'd7;
            7'b0000000: c = 5'd8;
            7'b0010000: c = 5'd9;
            7'b1111111: c = 5'h0F;
            default:    c = 5'h1F;
        endcase
        return c;
    endfunction

    logic [4:0] slot_m [8];
    logic [4:0] slot_z [4];
    logic [4:0] slot_8 [8];
    logic [4:0] slot_3 [3];
    logic [7:0] seen8 = 8'h00;
    logic [7:0] seen3 = 8'h00;
    int         err8 = 0;
    int         err3 = 0;
    int         err_m_hi = 0;

    logic       mon_en = 1'b0;
    logic       seen_new = 1'b0;
    int         old_hits = 0;
    int         mix_err = 0;
    logic [4:0] old_v [4] = '{5'd5, 5'd2, 5'h0F, 5'h0F};
    logic [4:0] new_v [4] = '{5'd0, 5'd0, 5'd6, 5'h0F};

    always @(negedge clk) begin
        if (en_m[7:4] != 4'hF) err_m_hi <= err_m_hi + 1;
        for (int k = 0; k < 4; k++) begin
            if (!en_m[k]) begin
                slot_m[k] <= seg2code(out7_m);
                if (mon_en) begin
                    if (seg2code(out7_m) == new_v[k] && new_v[k] != old_v[k]) seen_new <= 1'b1;
                    if (seg2code(out7_m) == old_v[k] && new_v[k] != old_v[k]) old_hits <= old_hits + 1;
                    if ((seen_new && seg2code(out7_m) != new_v[k]) ||
                        (seg2code(out7_m) != new_v[k] && seg2code(out7_m) != old_v[k]))
                        mix_err <= mix_err + 1;
                end
            end
            if (!en_z[k]) slot_z[k] <= seg2code(out7_z);
        end
    end

    always @(negedge clk) begin
        seen8 <= seen8 | ~en_8;
        if ($countones(~en_8) > 1) err8 <= err8 + 1;
        for (int k = 0; k < 8; k++) begin
            if (!en_8[k]) slot_8[k] <= seg2code(out7_8);
        end
    end

    always @(negedge clk) begin
        seen3 <= seen3 | ~en_3;
        if (en_3[7:3] != 5'h1F) err3 <= err3 + 1;
        for (int k = 0; k < 3; k++) begin
            if (!en_3[k]) slot_3[k] <= seg2code(out7_3);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_m && n < 40) begin
            tick(1);
            n++;
        end
        check(tag, 32'(busy_m), 32'h0);
    endtask

    task automatic check_main(input string tag, input logic [4:0] e0, input logic [4:0] e1,
                              input logic [4:0] e2, input logic [4:0] e3);
        check({tag, "_s0"}, 32'(slot_m[0]), 32'(e0));
        check({tag, "_s1"}, 32'(slot_m[1]), 32'(e1));
        check({tag, "_s2"}, 32'(slot_m[2]), 32'(e2));
        check({tag, "_s3"}, 32'(slot_m[3]), 32'(e3));
    endtask

    logic [7:0] en_seq [5] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFE};

    initial begin
        // Reset state
        tick(3);
        $display("[TB] reset held, Number=0");
        check("rst_busy", 32'(busy_m), 32'h0);
        check("rst_ovf",  32'(ov_m),   32'h0);
        check("rst_en",   32'(en_m),   32'hFF);
        check("rst_en8",  32'(en_8),   32'hFF);
        rst = 1'b0;

        // First post-reset conversion interleaved with the scan sequence
        tick(1);
        $display("[TB] reset released");
        check("rel_busy1", 32'(busy_m), 32'h1);
        check("scan_0", 32'(en_m), 32'(en_seq[0]));
        for (int i = 1; i < 4; i++) begin
            tick(4);
            check($sformatf("scan_%0d", i), 32'(en_m), 32'(en_seq[i]));
        end
        tick(2);
        check("rel_busy15", 32'(busy_m), 32'h1);
        tick(1);
        check("rel_busy16", 32'(busy_m), 32'h0);
        tick(1);
        check("scan_4", 32'(en_m), 32'(en_seq[4]));
        tick(18);
        check_main("zero", 5'd0, 5'h0F, 5'h0F, 5'h0F);

        // 1234 with exact latency
        number = 14'd1234;
        $display("[TB] Number=1234");
        tick(15);
        check("n1234_busy15", 32'(busy_m), 32'h1);
        tick(1);
        check("n1234_busy16", 32'(busy_m), 32'h0);
        check("n1234_ovf", 32'(ov_m), 32'h0);
        check("n1234_ovf3", 32'(ov_3), 32'h1);
        tick(18);
        check_main("n1234", 5'd4, 5'd3, 5'd2, 5'd1);

        // 7 with and without leading-zero blanking
        number = 14'd7;
        $display("[TB] Number=7");
        tick(16);
        tick(18);
        check_main("n7", 5'd7, 5'h0F, 5'h0F, 5'h0F);
        check("n7z_s0", 32'(slot_z[0]), 32'd7);
        check("n7z_s1", 32'(slot_z[1]), 32'd0);
        check("n7z_s2", 32'(slot_z[2]), 32'd0);
        check("n7z_s3", 32'(slot_z[3]), 32'd0);
        check("n7z_ovf", 32'(ov_z), 32'h0);
        check("n7z_busy", 32'(busy_z), 32'h0);

        // Overflow boundary
        number = 14'd9999;
        $display("[TB] Number=9999");
        tick(16);
        check("n9999_ovf", 32'(ov_m), 32'h0);
        check("n9999_ovf3", 32'(ov_3), 32'h1);
        tick(18);
        check_main("n9999", 5'd9, 5'd9, 5'd9, 5'd9);

        number = 14'd10000;
        $display("[TB] Number=10000");
        tick(16);
        check("n10000_ovf", 32'(ov_m), 32'h1);
        tick(18);
        check_main("n10000", 5'h0F, 5'h0F, 5'h0F, 5'h0F);

        number = 14'd999;
        $display("[TB] Number=999");
        tick(16);
        check("n999_ovf", 32'(ov_m), 32'h0);
        check("n999_ovf3", 32'(ov_3), 32'h0);
        tick(18);
        check_main("n999", 5'd9, 5'd9, 5'd9, 5'h0F);
        check("n999_d3_s0", 32'(slot_3[0]), 32'd9);
        check("n999_d3_s1", 32'(slot_3[1]), 32'd9);
        check("n999_d3_s2", 32'(slot_3[2]), 32'd9);

        // 25 then 600 while the first conversion is shifting
        number = 14'd25;
        $display("[TB] Number=25 then 600 mid-conversion");
        tick(3);
        number = 14'd600;
        wait_idle("n25_done");
        tick(1);
        check("n600_recapture", 32'(busy_m), 32'h1);
        mon_en = 1'b1;
        wait_idle("n600_done");
        tick(18);
        mon_en = 1'b0;
        check_main("n600", 5'd0, 5'd0, 5'd6, 5'h0F);
        check("n600_mixed", 32'(mix_err), 32'h0);
        check("n25_shown", 32'(old_hits != 0), 32'h1);

        // Reset in the middle of a conversion
        number = 14'd10000;
        $display("[TB] Number=10000 then 4321 with reset mid-conversion");
        tick(17);
        check("pre_rst_ovf", 32'(ov_m), 32'h1);
        number = 14'd4321;
        tick(5);
        rst = 1'b1;
        tick(1);
        check("mid_rst_busy", 32'(busy_m), 32'h0);
        check("mid_rst_en",   32'(en_m),   32'hFF);
        check("mid_rst_ovf",  32'(ov_m),   32'h0);
        rst = 1'b0;
        tick(1);
        check("post_rst_en",   32'(en_m), 32'hFE);
        check("post_rst_zero", 32'(seg2code(out7_m)), 32'd0);
        check("post_rst_busy1", 32'(busy_m), 32'h1);
        tick(14);
        check("post_rst_busy15", 32'(busy_m), 32'h1);
        tick(1);
        check("post_rst_busy16", 32'(busy_m), 32'h0);
        tick(18);
        check_main("n4321", 5'd1, 5'd2, 5'd3, 5'd4);

        // Wide and narrow instances
        tick(70);
        $display("[TB] 8-digit Number=12345678, 3-digit scan");
        for (int k = 0; k < 8; k++) begin
            check($sformatf("d8_s%0d", k), 32'(slot_8[k]), 32'(8 - k));
        end
        check("d8_seen", 32'(seen8), 32'hFF);
        check("d8_onehot", 32'(err8), 32'h0);
        check("d8_ovf", 32'(ov_8), 32'h0);
        check("d8_busy", 32'(busy_8), 32'h0);
        check("d3_seen", 32'(seen3), 32'h07);
        check("d3_hi_off", 32'(err3), 32'h0);
        check("d3_busy", 32'(busy_3), 32'h0);
        check("d3_ovf_s0", 32'(slot_3[0]), 32'h0F);
        check("main_hi_off", 32'(err_m_hi), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
